reorder_buffer: RTL
===================

# reorder_buffer

Circular in-order retirement buffer for the Tomasulo core. It sits between the issue stage and the register file. It allocates the 4-bit rename tag for each issued instruction, captures results broadcast on the CDB, and retires at most one instruction per cycle. Retirement drives the register file's commit port (`register_update_flag`/dest/value/rename) and raises the pipeline flush on a branch mispredict.

## Interface
- `ROB_DEPTH`, 16, number of entries; tag width is fixed at 4 bits, so ROB_DEPTH must equal 16.
- `clk` in 1, clock.
- `rst` in 1, reset, synchronous, active-high.
- `rdy` in 1, global enable; when low, all state and outputs hold.
- `alloc_valid` in 1, issue requests an entry this cycle.
- `alloc_has_rd` in 1, instruction writes rd.
- `alloc_rd` in 5, destination register.
- `alloc_is_branch` in 1, conditional branch.
- `alloc_is_store` in 1, store.
- `alloc_pred_taken` in 1, predictor decision.
- `alloc_pc` in 32, instruction PC.
- `alloc_ready` in 1, result already known (simple instruction, e.g. LUI).
- `alloc_value` in 32, value when alloc_ready.
- `alloc_tag` out 4, tag granted (current tail), combinational.
- `rob_full` out 1, count == 16, combinational from count.
- `cdb_valid` in 1, CDB broadcast.
- `cdb_tag` in 4, producing entry.
- `cdb_value` in 32, result.
- `cdb_taken` in 1, actual branch outcome.
- `cdb_target` in 32, branch target.
- `register_update_flag` out 1, one-cycle commit pulse to the register file.
- `register_commit_dest` out 5, committed rd.
- `register_commit_value` out 32, committed value.
- `rename_of_commit_ins` out 4, committed tag.
- `store_commit` out 1, one-cycle pulse; head store may write memory.
- `store_commit_tag` out 4, tag of the committed store.
- `rob_flush` out 1, one-cycle mispredict flush; drives `register_flush` and the upstream flush.
- `flush_pc` out 32, correct fetch PC.

## Operation
- Per-entry state:
  - busy
  - ready
  - has_rd
  - rd
  - value
  - is_branch
  - is_store
  - pred_taken
  - taken
  - target
  - pc
- Pointers: head[3:0] and tail[3:0], both wrap modulo 16. count[4:0] covers 0..16.
- Allocate: when `alloc_valid && !rob_full && !flush_now`:
  - write the entry at tail with busy=1 and ready=alloc_ready (value=alloc_value if ready);
  - tail++.
  - `alloc_valid` while full is ignored. Issue must stall on `rob_full`.
- Capture: when `cdb_valid` and entry[cdb_tag].busy, set ready=1 and latch value, taken and target. A CDB write to a non-busy entry is ignored.
- Commit: when head entry is busy and ready:
  - clear busy; head++.
  - If has_rd and rd != 0: pulse `register_update_flag` with dest/value/tag.
  - If is_store: pulse `store_commit`.
  - If is_branch and taken != pred_taken:
    - pulse `rob_flush`;
    - set `flush_pc` = taken ? target : pc+4 (32-bit wrap);
    - no register update.
- Flush (`flush_now` = mispredict commit this cycle):
  - takes effect next cycle: all busy=0, head=tail=0, count=0;
  - a same-cycle alloc or CDB write is discarded.
- Count: count += alloc_accepted − committed, evaluated against pre-update values. At count==16, allocation is refused even when a commit occurs in the same cycle.
- Reset values:
  - all pulse outputs 0;
  - `flush_pc`, commit dest/value/tag and `store_commit_tag` are 0;
  - head=tail=count=0; all busy=0.
- `rdy` low: nothing changes; pulses already high stay high until the next enabled cycle, where they clear unless re-driven.

## Timing
- Commit outputs are registered and appear one cycle after the head becomes ready (without bypass).
- A CDB write to the head entry commits on the following cycle. An alloc_ready entry at an empty head commits the cycle after allocation.
- Throughput: at most one allocation and one commit per cycle.
- `rob_flush` is high for exactly one enabled cycle. The first allocation after a flush receives tag 0 in the cycle after `rob_flush`.

## Configuration
- `ROB_HEAD_BYPASS_EN`:
  - Defined: a CDB broadcast whose tag equals head (head busy, not yet ready) commits in the same cycle, using `cdb_value`/`cdb_taken`/`cdb_target` directly. This saves one cycle of commit latency.
  - Undefined: the CDB only marks the entry ready; commit follows next cycle.

## Test plan
- Reset, then check idle outputs: `alloc_tag`=0, `rob_full`=0, all pulses 0.
- Three ALU allocs (rd=5,6,7 → tags 0,1,2), then CDB to tags 2,0,1 → commits in order: x5, x6, x7 on three consecutive cycles with `rename_of_commit_ins` 0,1,2.
- 16 allocs → `rob_full`=1; 17th alloc ignored (tail stays 0). Then commit head → `rob_full`=0, and the next alloc gets tag 0 (wrap).
- Branch at pc=0x100 with pred_taken=0, CDB taken=1, target=0x200 → `rob_flush`=1 and `flush_pc`=0x200 for one cycle, no `register_update_flag`, younger entries dropped, next alloc tag 0.
- Store entry → `store_commit`=1 with its tag and `register_update_flag`=0. An rd=0 ALU entry commits with no register pulse.
- CDB to the head tag: commits in the same cycle with `ROB_HEAD_BYPASS_EN` defined, one cycle later without it. Toggling `rdy`=0 for 3 cycles mid-sequence leaves head, tail, count and the commit order unchanged.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Issue, CDB and commit signal bundle between the Tomasulo front end and reorder_buffer.
// master = issue/CDB/register-file side, slave = the reorder buffer.
interface reorder_buffer_if;
    logic        rdy;

    logic        alloc_valid;
    logic        alloc_has_rd;
    logic [4:0]  alloc_rd;
    logic        alloc_is_branch;
    logic        alloc_is_store;
    logic        alloc_pred_taken;
    logic [31:0] alloc_pc;
    logic        alloc_ready;
    logic [31:0] alloc_value;
    logic [3:0]  alloc_tag;
    logic        rob_full;

    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;

    logic        register_update_flag;
    logic [4:0]  register_commit_dest;
    logic [31:0] register_commit_value;
    logic [3:0]  rename_of_commit_ins;
    logic        store_commit;
    logic [3:0]  store_commit_tag;
    logic        rob_flush;
    logic [31:0] flush_pc;

    modport master (
        output rdy,
        output alloc_valid, alloc_has_rd, alloc_rd, alloc_is_branch, alloc_is_store,
        output alloc_pred_taken, alloc_pc, alloc_ready, alloc_value,
        input  alloc_tag, rob_full,
        output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        input  register_update_flag, register_commit_dest, register_commit_value,
        input  rename_of_commit_ins, store_commit, store_commit_tag, rob_flush, flush_pc
    );

    modport slave (
        input  rdy,
        input  alloc_valid, alloc_has_rd, alloc_rd, alloc_is_branch, alloc_is_store,
        input  alloc_pred_taken, alloc_pc, alloc_ready, alloc_value,
        output alloc_tag, rob_full,
        input  cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        output register_update_flag, register_commit_dest, register_commit_value,
        output rename_of_commit_ins, store_commit, store_commit_tag, rob_flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: tag allocation, CDB capture, in-order single retirement.
// Optional ROB_HEAD_BYPASS_EN lets a CDB write to the waiting head commit in the same cycle.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16  // tags are 4 bits wide, so this must stay 16
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob
);
    typedef struct packed {
        logic        ready;
        logic        has_rd;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        is_branch;
        logic        is_store;
        logic        pred_taken;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
    } entry_t;

    logic [ROB_DEPTH-1:0] busy;
    entry_t               ent [ROB_DEPTH];
    logic [3:0]           head;
    logic [3:0]           tail;
    logic [4:0]           count;

    entry_t      head_ent;
    entry_t      new_ent;
    logic        head_busy;
    logic        bypass_hit;
    logic        commit;
    logic        mispredict;
    logic        alloc_ok;
    logic        cdb_hit;
    logic        reg_write;
    logic [31:0] c_value;
    logic [31:0] c_target;
    logic        c_taken;

    assign head_ent  = ent[head];
    assign head_busy = busy[head];

`ifdef ROB_HEAD_BYPASS_EN
    assign bypass_hit = rob.cdb_valid && (rob.cdb_tag == head) && head_busy && !head_ent.ready;
`else
    assign bypass_hit = 1'b0;
`endif

    // Result fields of the retiring entry, taken straight off the CDB on a bypass.
    assign c_value  = bypass_hit ? rob.cdb_value  : head_ent.value;
    assign c_taken  = bypass_hit ? rob.cdb_taken  : head_ent.taken;
    assign c_target = bypass_hit ? rob.cdb_target : head_ent.target;

    assign commit     = head_busy && (head_ent.ready || bypass_hit);
    assign mispredict = commit && head_ent.is_branch && (c_taken != head_ent.pred_taken);
    assign reg_write  = commit && !mispredict && head_ent.has_rd && (head_ent.rd != 5'd0);
    assign cdb_hit    = rob.cdb_valid && busy[rob.cdb_tag];

    assign rob.rob_full  = (count == 5'd16);
    assign rob.alloc_tag = tail;
    assign alloc_ok      = rob.alloc_valid && !rob.rob_full && !mispredict;

    always_comb begin
        new_ent            = '0;
        new_ent.ready      = rob.alloc_ready;
        new_ent.has_rd     = rob.alloc_has_rd;
        new_ent.rd         = rob.alloc_rd;
        new_ent.value      = rob.alloc_ready ? rob.alloc_value : 32'd0;
        new_ent.is_branch  = rob.alloc_is_branch;
        new_ent.is_store   = rob.alloc_is_store;
        new_ent.pred_taken = rob.alloc_pred_taken;
        new_ent.pc         = rob.alloc_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy                      <= '0;
            head                      <= 4'd0;
            tail                      <= 4'd0;
            count                     <= 5'd0;
            rob.register_update_flag  <= 1'b0;
            rob.register_commit_dest  <= 5'd0;
            rob.register_commit_value <= 32'd0;
            rob.rename_of_commit_ins  <= 4'd0;
            rob.store_commit          <= 1'b0;
            rob.store_commit_tag      <= 4'd0;
            rob.rob_flush             <= 1'b0;
            rob.flush_pc              <= 32'd0;
        end else if (rob.rdy) begin
            rob.register_update_flag <= reg_write;
            rob.store_commit         <= commit && head_ent.is_store;
            rob.rob_flush            <= mispredict;
            if (reg_write) begin
                rob.register_commit_dest  <= head_ent.rd;
                rob.register_commit_value <= c_value;
                rob.rename_of_commit_ins  <= head;
            end
            if (commit && head_ent.is_store)
                rob.store_commit_tag <= head;
            if (mispredict)
                rob.flush_pc <= c_taken ? c_target : head_ent.pc + 32'd4;

            // A mispredict squashes everything, including this cycle's alloc and CDB write.
            if (mispredict) begin
                busy  <= '0;
                head  <= 4'd0;
                tail  <= 4'd0;
                count <= 5'd0;
            end else begin
                if (cdb_hit) begin
                    ent[rob.cdb_tag].ready  <= 1'b1;
                    ent[rob.cdb_tag].value  <= rob.cdb_value;
                    ent[rob.cdb_tag].taken  <= rob.cdb_taken;
                    ent[rob.cdb_tag].target <= rob.cdb_target;
                end
                if (commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 4'd1;
                end
                // tail never aliases a busy head here: alloc is refused when full
                if (alloc_ok) begin
                    busy[tail] <= 1'b1;
                    ent[tail]  <= new_ent;
                    tail       <= tail + 4'd1;
                end
                count <= count + {4'd0, alloc_ok} - {4'd0, commit};
            end
        end
    end
endmodule
